// File: rtl/sb_pkg.sv
// Shared types and constants for the store buffer: entry layout, FSM states, count-width helper.
package sb_pkg;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned DATA_W      = WORD_BYTES * 8;
    localparam int unsigned ADDR_MAX_W  = 64;
    localparam int unsigned WORD_ADDR_W = ADDR_MAX_W - 2;

    typedef enum logic {
        IDLE,
        DRAIN
    } sb_state_e;

    // Word address is zero-extended into a fixed-width field so the struct is AW-independent.
    typedef struct packed {
        logic [WORD_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      data;
        logic [WORD_BYTES-1:0]  be;
        logic                   valid;
    } sb_entry_t;

    function automatic int unsigned sb_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Per-lane age-priority merge of buffered stores matching a load word address.
// Compiled only when STORE_FWD_EN is defined (the only build that instantiates it).
`ifdef STORE_FWD_EN
module sb_fwd_merge
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  sb_entry_t                entries_i [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head_i,
    input  logic [WORD_ADDR_W-1:0]   ld_word_i,
    output logic [DATA_W-1:0]        fwd_data_o,
    output logic [WORD_BYTES-1:0]    fwd_be_o,
    output logic                     hit_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] idx_c;

    // Walk oldest to youngest so younger entries overwrite older lanes.
    always_comb begin
        fwd_data_o = '0;
        fwd_be_o   = '0;
        hit_o      = 1'b0;
        idx_c      = head_i;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx_c = head_i + PTR_W'(i);
            if (entries_i[idx_c].valid && (entries_i[idx_c].addr == ld_word_i)) begin
                hit_o = 1'b1;
                for (int unsigned b = 0; b < WORD_BYTES; b++) begin
                    if (entries_i[idx_c].be[b]) begin
                        fwd_be_o[b]          = 1'b1;
                        fwd_data_o[8*b +: 8] = entries_i[idx_c].data[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule
`endif

// File: rtl/store_buffer.sv
// In-order posted-write buffer with memory drain, load conflict/forwarding and flush.
// Define STORE_FWD_EN to enable byte forwarding from buffered stores to loads.
module store_buffer
    import sb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [AW-1:0]                st_addr,
    input  logic [31:0]                  st_data,
    input  logic [3:0]                   st_be,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [AW-1:0]                mem_addr,
    output logic [31:0]                  mem_wdata,
    output logic [3:0]                   mem_be,
    input  logic [AW-1:0]                ld_addr,
    input  logic [3:0]                   ld_be,
    output logic                         ld_conflict,
    output logic [31:0]                  fwd_data,
    output logic [3:0]                   fwd_be,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [sb_cnt_w(DEPTH)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = sb_cnt_w(DEPTH);

    sb_entry_t              entries_q [DEPTH];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [CNT_W-1:0]       count_q;
    sb_state_e              state_q;
    logic                   enq_c;
    logic                   deq_c;
    logic [WORD_ADDR_W-1:0] ld_word_c;
    logic                   unused_addr_lsb;

    assign unused_addr_lsb = ^{st_addr[1:0], ld_addr[1:0]};

    assign count      = count_q;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign st_ready   = !full && (state_q == IDLE);
    assign enq_c      = st_valid && st_ready && (st_be != '0);
    assign mem_valid  = !empty;
    assign deq_c      = mem_valid && mem_ready;
    assign flush_done = (state_q == DRAIN) && empty;
    assign ld_word_c  = WORD_ADDR_W'(ld_addr[AW-1:2]);

    assign mem_addr  = {entries_q[head_q].addr[AW-3:0], 2'b00};
    assign mem_wdata = entries_q[head_q].data;
    assign mem_be    = entries_q[head_q].be;

    // Queue storage, pointers, occupancy and flush FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            state_q <= IDLE;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (enq_c) begin
                entries_q[tail_q] <= '{addr:  WORD_ADDR_W'(st_addr[AW-1:2]),
                                       data:  st_data,
                                       be:    st_be,
                                       valid: 1'b1};
                tail_q <= tail_q + PTR_W'(1);
            end
            if (deq_c) begin
                entries_q[head_q].valid <= 1'b0;
                head_q <= head_q + PTR_W'(1);
            end
            case ({enq_c, deq_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            case (state_q)
                IDLE:    if (flush) state_q <= DRAIN;
                DRAIN:   if (empty) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef STORE_FWD_EN
    logic hit_c;

    sb_fwd_merge #(
        .DEPTH (DEPTH)
    ) u_fwd_merge (
        .entries_i  (entries_q),
        .head_i     (head_q),
        .ld_word_i  (ld_word_c),
        .fwd_data_o (fwd_data),
        .fwd_be_o   (fwd_be),
        .hit_o      (hit_c)
    );

    // Stall only when some requested lane cannot be supplied by the buffer.
    assign ld_conflict = hit_c && ((ld_be & ~fwd_be) != '0);
`else
    assign fwd_data = '0;
    assign fwd_be   = '0;

    // Without forwarding any overlapping buffered byte forces a stall.
    always_comb begin
        ld_conflict = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[i].valid && (entries_q[i].addr == ld_word_c) &&
                ((entries_q[i].be & ld_be) != '0)) begin
                ld_conflict = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_be;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic [3:0]  ld_be;
    logic        ld_conflict;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_be;
    logic        flush;
    logic        flush_done;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    always #5 clk = ~clk;

    store_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_be       (st_be),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .ld_addr     (ld_addr),
        .ld_be       (ld_be),
        .ld_conflict (ld_conflict),
        .fwd_data    (fwd_data),
        .fwd_be      (fwd_be),
        .flush       (flush),
        .flush_done  (flush_done),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    typedef struct {
        logic [29:0] w;
        logic [31:0] d;
        logic [3:0]  b;
    } ment_t;

    ment_t mq[$];
    bit    m_drain;
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected outputs derived from the model queue and the current load inputs.
    task automatic model_check();
        int          n;
        logic [3:0]  ebe;
        logic [31:0] edata;
        bit          hit;
        bit          overlap;
        n       = mq.size();
        ebe     = '0;
        edata   = '0;
        hit     = 1'b0;
        overlap = 1'b0;
        check("count", 64'(count), 64'(n));
        check("full", 64'(full), 64'(n == DEPTH));
        check("empty", 64'(empty), 64'(n == 0));
        check("st_ready", 64'(st_ready), 64'((n < DEPTH) && !m_drain));
        check("mem_valid", 64'(mem_valid), 64'(n > 0));
        check("flush_done", 64'(flush_done), 64'(m_drain && (n == 0)));
        if (n > 0) begin
            check("mem_addr", 64'(mem_addr), 64'({mq[0].w, 2'b00}));
            check("mem_wdata", 64'(mem_wdata), 64'(mq[0].d));
            check("mem_be", 64'(mem_be), 64'(mq[0].b));
        end
        foreach (mq[i]) begin
            if (mq[i].w == ld_addr[31:2]) begin
                hit = 1'b1;
                if ((mq[i].b & ld_be) != 4'b0) overlap = 1'b1;
            end
        end
        // Each lane takes its byte from the youngest matching store that wrote it.
        for (int l = 0; l < 4; l++) begin
            for (int i = n - 1; i >= 0; i--) begin
                if ((mq[i].w == ld_addr[31:2]) && mq[i].b[l]) begin
                    ebe[l] = 1'b1;
                    edata[8*l +: 8] = mq[i].d[8*l +: 8];
                    break;
                end
            end
        end
`ifdef STORE_FWD_EN
        check("fwd_be", 64'(fwd_be), 64'(ebe));
        check("fwd_data", 64'(fwd_data), 64'(edata));
        check("ld_conflict", 64'(ld_conflict), 64'(hit && ((ld_be & ~ebe) != 4'b0)));
`else
        check("fwd_be", 64'(fwd_be), 64'(0));
        check("fwd_data", 64'(fwd_data), 64'(0));
        check("ld_conflict", 64'(ld_conflict), 64'(overlap));
`endif
    endtask

    task automatic model_update();
        int n;
        bit enq;
        bit deq;
        n = mq.size();
        if (reset) begin
            mq.delete();
            m_drain = 1'b0;
            return;
        end
        deq = (n > 0) && mem_ready;
        enq = st_valid && (n < DEPTH) && !m_drain && (st_be != 4'b0);
        if (!m_drain && flush) m_drain = 1'b1;
        else if (m_drain && (n == 0)) m_drain = 1'b0;
        if (deq) void'(mq.pop_front());
        if (enq) mq.push_back('{w: st_addr[31:2], d: st_data, b: st_be});
    endtask

    task automatic drive(input logic rst, input logic sv, input logic [31:0] sa,
                         input logic [31:0] sd, input logic [3:0] sbe,
                         input logic mr, input logic fl);
        reset     = rst;
        st_valid  = sv;
        st_addr   = sa;
        st_data   = sd;
        st_be     = sbe;
        mem_ready = mr;
        flush     = fl;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #2;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input logic mr);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, mr, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        ld_addr = 32'h0;
        ld_be   = 4'h0;
        m_drain = 1'b0;
        @(negedge clk);
        @(posedge clk);
        model_update();
        @(negedge clk);

        // Reset state and single store held by memory back-pressure.
        idle(1'b0);
        #1;
        check("rst_mem_valid", 64'(mem_valid), 64'(0));
        check("rst_st_ready", 64'(st_ready), 64'(1));
        check("rst_empty", 64'(empty), 64'(1));
        drive(1'b0, 1'b1, 32'h100, 32'hAABBCCDD, 4'hF, 1'b0, 1'b0);
        cycle();
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            #1;
            check("t1_valid", 64'(mem_valid), 64'(1));
            check("t1_addr", 64'(mem_addr), 64'(32'h100));
            check("t1_data", 64'(mem_wdata), 64'(32'hAABBCCDD));
            cycle();
        end
        idle(1'b1);
        cycle();
        idle(1'b0);
        #1;
        check("t1_empty", 64'(empty), 64'(1));
        cycle();

        // Fill, hold a fifth store, then drain in order.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 32'h100 + 32'(4 * k), $urandom, 4'hF, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b1, 32'h110, 32'h5555_5555, 4'hF, 1'b0, 1'b0);
        #1;
        check("t2_full", 64'(full), 64'(1));
        check("t2_st_ready", 64'(st_ready), 64'(0));
        cycle();
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            #1;
            check("t2_drain_addr", 64'(mem_addr), 64'(32'h100 + 32'(4 * k)));
            cycle();
        end

        // Full buffer with store and retire both requested.
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 32'h180 + 32'(4 * k), $urandom, 4'hF, 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 1'b1, 32'h1A0, 32'h1, 4'hF, 1'b1, 1'b0);
        cycle();
        #1;
        check("t3_count_after_full", 64'(count), 64'(3));
        cycle();
        #1;
        check("t3_count_steady", 64'(count), 64'(3));
        idle(1'b1);
        for (int k = 0; k < 4; k++) cycle();

        // Two overlapping stores to one word, then load checks.
        drive(1'b0, 1'b1, 32'h200, 32'h0000_1122, 4'b0011, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 32'h201, 32'h0033_4400, 4'b0110, 1'b0, 1'b0);
        cycle();
        idle(1'b0);
        ld_addr = 32'h202;
        ld_be   = 4'b0111;
        #1;
`ifdef STORE_FWD_EN
        check("t4_fwd_be", 64'(fwd_be), 64'(4'b0111));
        check("t4_fwd_data", 64'(fwd_data), 64'(32'h0033_4422));
        check("t4_conflict_full_hit", 64'(ld_conflict), 64'(0));
`else
        check("t4_conflict_overlap", 64'(ld_conflict), 64'(1));
`endif
        cycle();
        ld_be = 4'b1000;
        #1;
`ifdef STORE_FWD_EN
        check("t4_conflict_partial", 64'(ld_conflict), 64'(1));
`else
        check("t4_conflict_disjoint", 64'(ld_conflict), 64'(0));
`endif
        cycle();

        // Flush with two entries pending, then flush while empty.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        cycle();
        idle(1'b1);
        #1;
        check("t5_st_ready_drain", 64'(st_ready), 64'(0));
        check("t5_done_early", 64'(flush_done), 64'(0));
        cycle();
        #1;
        check("t5_done", 64'(flush_done), 64'(1));
        check("t5_count0", 64'(count), 64'(0));
        cycle();
        #1;
        check("t5_idle_ready", 64'(st_ready), 64'(1));
        check("t5_done_clear", 64'(flush_done), 64'(0));
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        cycle();
        idle(1'b0);
        #1;
        check("t5_empty_flush_done", 64'(flush_done), 64'(1));
        cycle();

        // Reset while three stores are queued.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 32'h300 + 32'(4 * k), $urandom, 4'hF, 1'b0, 1'b0);
            cycle();
        end
        ld_addr = 32'h300;
        ld_be   = 4'hF;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        #1;
        check("t6_valid_before", 64'(mem_valid), 64'(1));
        cycle();
        idle(1'b1);
        #1;
        check("t6_mem_valid", 64'(mem_valid), 64'(0));
        check("t6_count", 64'(count), 64'(0));
        check("t6_fwd_be", 64'(fwd_be), 64'(0));
        check("t6_conflict", 64'(ld_conflict), 64'(0));
        for (int k = 0; k < 3; k++) cycle();

        // Random traffic on a small address pool so loads hit often.
        for (int k = 0; k < 800; k++) begin
            drive(($urandom % 64) == 0,
                  ($urandom % 4) != 0,
                  32'h100 + 32'(4 * ($urandom % 8)) + 32'($urandom % 4),
                  $urandom,
                  (($urandom % 8) == 0) ? 4'h0 : 4'($urandom),
                  ($urandom % 3) != 0,
                  ($urandom % 32) == 0);
            ld_addr = 32'h100 + 32'(4 * ($urandom % 8)) + 32'($urandom % 4);
            ld_be   = 4'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the core's store-alignment stage (aligned write data plus byte enables) and the data memory port.
- Accepts one store per cycle, queues stores in order, and drains them to memory over a valid/ready handshake.
- Supplies load-address conflict and byte-forwarding information so loads observe buffered stores.
- Provides a flush/fence drain for memory-ordering points.

Parameters:
DEPTH, 4, number of store entries; power of two, at least 2
AW, 32, address width in bits

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
st_valid  in  1  store request from the core
st_ready  out  1  buffer can accept a store this cycle
st_addr  in  AW  store byte address; bits [1:0] are ignored for storage (word-granular entries)
st_data  in  32  lane-aligned write data
st_be  in  4  byte enables; 4'b0000 is accepted and discarded (no entry)
mem_valid  out  1  head entry presented to memory
mem_ready  in  1  memory accepts the head entry
mem_addr  out  AW  head word address ({addr[AW-1:2],2'b00})
mem_wdata  out  32  head data
mem_be  out  4  head byte enables
ld_addr  in  AW  address of the current load
ld_be  in  4  bytes the load requires
ld_conflict  out  1  load must stall
fwd_data  out  32  forwarded bytes
fwd_be  out  4  valid forwarded byte lanes
flush  in  1  request to drain all entries
flush_done  out  1  one-cycle pulse: buffer empty after a flush
count  out  $clog2(DEPTH+1)  occupied entries
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Storage is a circular FIFO with head pointer, tail pointer and count, all registered.
- Reset (synchronous, any time, including mid-drain):
  - pointers, count, valid bits and state are cleared; pending stores are discarded.
  - In the cycle after the reset edge: mem_valid=0, st_ready=1, empty=1, full=0, flush_done=0, fwd_be=0, ld_conflict=0.
- Enqueue:
  - Occurs on st_valid && st_ready && st_be!=0; the entry is written at the tail.
  - st_ready = !full && state==IDLE. There is no pass-through when full, even if a dequeue happens the same cycle.
- Dequeue:
  - mem_valid = !empty.
  - mem_addr, mem_wdata and mem_be come combinationally from the registered head entry and stay stable until mem_ready.
  - The head retires on mem_valid && mem_ready.
- Latency: a store accepted at edge N is presented on mem_* in the cycle after edge N (1 cycle, minimum).
- Simultaneous enqueue and dequeue: count unchanged; both pointers advance.
- Pointer wrap: pointers wrap modulo DEPTH. Full/empty are derived only from count.
- FSM:
  - IDLE: flush=1 -> DRAIN.
  - DRAIN: st_ready=0; draining continues; flush_done = (count==0); when count==0, go to IDLE at the next edge.
  - Flush while empty: DRAIN is entered, and flush_done pulses in the following cycle.
  - flush held high for extra cycles is ignored while in DRAIN.
- Load check (combinational, registered entries only; a store being enqueued in the same cycle is not visible):
  - An entry matches when its addr[AW-1:2] == ld_addr[AW-1:2].
  - The youngest matching entry wins per byte lane.

Optional Feature:
STORE_FWD_EN
- Defined:
  - Per-lane youngest-first merge over matching entries.
  - fwd_be = OR of matching entries' be.
  - fwd_data = merged bytes; lanes not in fwd_be are 0.
  - ld_conflict = any match && ((ld_be & ~fwd_be) != 0), i.e. a partial hit stalls.
- Undefined:
  - fwd_be=0, fwd_data=0.
  - ld_conflict = any match with (entry.be & ld_be) != 0.

Decomposition:
- Package sb_pkg holds:
  - sb_entry_t {addr word, data, be, valid}
  - sb_state_e {IDLE, DRAIN}
  - WORD_BYTES=4
  - the count-width helper
- Sub-module sb_fwd_merge holds the combinational per-lane age-priority merge, taking the entry array and head pointer. It is instantiated only under STORE_FWD_EN.

Test Plan:
1. reset; store addr 0x100, data 0xAABBCCDD, be 4'b1111, mem_ready=0 for 3 cycles -> mem_valid high from next cycle, payload stable, retires on the mem_ready cycle, empty=1 after.
2. 4 back-to-back stores with mem_ready=0 -> full=1, st_ready=0, 5th store held; mem_ready=1 -> in-order drain 0x100..0x10C, one per cycle; pointers wrap correctly on a second burst of 4.
3. Full buffer, st_valid and mem_ready both high -> no enqueue that cycle, count 4->3; next cycle enqueue+dequeue, count stays 3.
4. Stores 0x200 be=0011 data 0x0000_1122, then 0x200 be=0110 data 0x0033_4400; load 0x200 ld_be=0111 -> FWD: fwd_be=0111, fwd_data=0x0033_4422, ld_conflict=0; no-FWD: ld_conflict=1. Load 0x200 ld_be=1000 -> FWD: ld_conflict=1; no-FWD: ld_conflict=0.
5. 2 entries queued, flush pulse, mem_ready=1 -> st_ready=0 during drain, flush_done high exactly in the cycle count==0, then IDLE with st_ready=1; flush while empty -> flush_done pulses next cycle.
6. 3 entries queued, mem_valid high, reset asserted one cycle -> next cycle mem_valid=0, count=0, fwd_be=0, no memory write issued afterwards.
